// File: rtl/conv_mac_engine.sv
// Convolution multiply-accumulate engine.
// Accepts one KxK patch/kernel pair plus a bias, folds the patch into a wide
// accumulator LANES products per cycle, then adds the bias, applies optional
// ReLU and saturates to a signed OUT_W result held until the consumer takes it.
module conv_mac_engine #(
  parameter int DATA_W = 8,
  parameter int K      = 3,
  parameter int LANES  = 3,
  parameter int BIAS_W = 16,
  parameter int OUT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [K*K*DATA_W-1:0]   in_patch,
  input  logic [K*K*DATA_W-1:0]   in_kernel,
  input  logic [BIAS_W-1:0]       in_bias,
  input  logic                    relu_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_pixel,
  output logic                    out_sat
);

  localparam int NE     = K * K;
  localparam int N      = NE / LANES;
  localparam int PROD_W = 2 * DATA_W;
  localparam int ACC_W  = 2 * DATA_W + $clog2(NE) + 1;
  localparam int MAX_AB = (ACC_W > BIAS_W) ? ACC_W : BIAS_W;
  // One guard bit above the widest operand so acc + bias never wraps.
  localparam int SUM_W  = ((MAX_AB > OUT_W) ? MAX_AB : OUT_W) + 1;
  localparam int GW     = (N > 1) ? $clog2(N) : 1;

  localparam logic signed [SUM_W-1:0] OUT_MAX = {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] OUT_MIN = {{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, FINISH, OUT} state_t;

  state_t                    state_q, state_d;
  logic [NE*DATA_W-1:0]      patch_q, patch_d;
  logic [NE*DATA_W-1:0]      kernel_q, kernel_d;
  logic [BIAS_W-1:0]         bias_q, bias_d;
  logic                      relu_q, relu_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [GW-1:0]             grp_q, grp_d;
  logic [OUT_W-1:0]          pix_q, pix_d;
  logic                      sat_q, sat_d;
  logic                      init_done_q;

  logic signed [PROD_W-1:0]  lane_prod [LANES];
  logic signed [ACC_W-1:0]   group_sum;
  logic signed [SUM_W-1:0]   sum_raw;
  logic signed [SUM_W-1:0]   sum_relu;
  logic [OUT_W-1:0]          clamp_val;
  logic                      clamp_hit;

  assign in_ready  = (state_q == IDLE) && init_done_q;
  assign out_valid = (state_q == OUT);
  assign out_pixel = pix_q;
  assign out_sat   = sat_q;

  // Each lane selects its element of the current group, so only LANES
  // multipliers exist regardless of the patch size.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic signed [DATA_W-1:0] px;
      logic signed [DATA_W-1:0] wt;

      // Operand mux: element g*LANES+gi for the active group g.
      always_comb begin
        px = '0;
        wt = '0;
        for (int g = 0; g < N; g++) begin
          if (grp_q == GW'(g)) begin
            px = patch_q[(g*LANES+gi)*DATA_W +: DATA_W];
            wt = kernel_q[(g*LANES+gi)*DATA_W +: DATA_W];
          end
        end
      end

      assign lane_prod[gi] = px * wt;
    end
  endgenerate

  // Adder tree for the products of the active group, sign-extended to ACC_W.
  always_comb begin
    group_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      group_sum = group_sum + {{(ACC_W-PROD_W){lane_prod[l][PROD_W-1]}}, lane_prod[l]};
    end
  end

  // Bias add, optional ReLU, then saturation to the output range.
  always_comb begin
    sum_raw   = {{(SUM_W-ACC_W){acc_q[ACC_W-1]}}, acc_q}
              + {{(SUM_W-BIAS_W){bias_q[BIAS_W-1]}}, bias_q};
    sum_relu  = (relu_q && sum_raw[SUM_W-1]) ? '0 : sum_raw;
    clamp_val = sum_relu[OUT_W-1:0];
    clamp_hit = 1'b0;
    if (sum_relu > OUT_MAX) begin
      clamp_val = OUT_MAX[OUT_W-1:0];
      clamp_hit = 1'b1;
    end else if (sum_relu < OUT_MIN) begin
      clamp_val = OUT_MIN[OUT_W-1:0];
      clamp_hit = 1'b1;
    end
  end

  // Next-state and datapath update for the IDLE -> MAC -> FINISH -> OUT job flow.
  always_comb begin
    state_d  = state_q;
    patch_d  = patch_q;
    kernel_d = kernel_q;
    bias_d   = bias_q;
    relu_d   = relu_q;
    acc_d    = acc_q;
    grp_d    = grp_q;
    pix_d    = pix_q;
    sat_d    = sat_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          patch_d  = in_patch;
          kernel_d = in_kernel;
          bias_d   = in_bias;
          relu_d   = relu_en;
          acc_d    = '0;
          grp_d    = '0;
          state_d  = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + group_sum;
        if (grp_q == GW'(N-1)) begin
          state_d = FINISH;
        end else begin
          grp_d = grp_q + 1'b1;
        end
      end
      FINISH: begin
        pix_d   = clamp_val;
        sat_d   = clamp_hit;
        state_d = OUT;
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; in_ready is held off until the first edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_done_q <= 1'b1;
    end
  end

  // Job operands, accumulator and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      patch_q  <= '0;
      kernel_q <= '0;
      bias_q   <= '0;
      relu_q   <= 1'b0;
      acc_q    <= '0;
      grp_q    <= '0;
      pix_q    <= '0;
      sat_q    <= 1'b0;
    end else begin
      patch_q  <= patch_d;
      kernel_q <= kernel_d;
      bias_q   <= bias_d;
      relu_q   <= relu_d;
      acc_q    <= acc_d;
      grp_q    <= grp_d;
      pix_q    <= pix_d;
      sat_q    <= sat_d;
    end
  end

endmodule

// File: doc/conv_mac_engine.md
CONV_MAC_ENGINE -- requirements
Module: conv_mac_engine

Parameters
REQ-001 SHALL have parameter DATA_W, default 8: signed two's-complement width of each pixel and each weight.
REQ-002 SHALL have parameter K, default 3: kernel side; a patch holds K*K elements.
REQ-003 SHALL have parameter LANES, default 3: multipliers used per cycle; K*K mod LANES SHALL be 0; N = K*K/LANES.
REQ-004 SHALL have parameter BIAS_W, default 16: signed bias width.
REQ-005 SHALL have parameter OUT_W, default 16: signed output width.

Interface
REQ-006 clk  in  1  clock; all state updates on its rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 in_valid  in  1  patch, kernel, bias and mode are valid.
REQ-009 in_ready  out  1  engine can accept a job.
REQ-010 in_patch  in  K*K*DATA_W  element i (i = row*K+col) at bits [i*DATA_W +: DATA_W].
REQ-011 in_kernel  in  K*K*DATA_W  weights, same packing as in_patch.
REQ-012 in_bias  in  BIAS_W  signed bias.
REQ-013 relu_en  in  1  apply ReLU to this job.
REQ-014 out_valid  out  1  result available.
REQ-015 out_ready  in  1  consumer takes the result.
REQ-016 out_pixel  out  OUT_W  signed, saturated result.
REQ-017 out_sat  out  1  result was clamped.

Function
REQ-018 SHALL implement FSM states IDLE, MAC, FINISH, OUT.
REQ-019 in_ready SHALL be 1 only in IDLE. Accept = in_valid && in_ready on a rising edge. Accept SHALL register patch, kernel, bias and relu_en, clear the accumulator and group index, and enter MAC.
REQ-020 MAC: each cycle, group g (elements g*LANES .. g*LANES+LANES-1) SHALL be multiplied, summed and added to the accumulator, then g increments; after g = N-1 the FSM SHALL enter FINISH.
REQ-021 Accumulator width SHALL be ACC_W = 2*DATA_W + clog2(K*K) + 1 bits, signed, so that no internal overflow can occur.
REQ-022 FINISH (1 cycle): the engine SHALL compute acc + sign-extended bias. If relu_en is set, a negative value SHALL become 0. The value SHALL then be clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1], out_pixel and out_sat registered, and the FSM SHALL enter OUT.
REQ-023 out_sat SHALL be 1 only if clamping changed the value; a ReLU-zeroed result SHALL give out_sat=0.
REQ-024 OUT: out_valid SHALL be 1. out_pixel and out_sat SHALL hold stable until out_valid && out_ready, then the FSM SHALL return to IDLE with out_valid=0.
REQ-025 Latency: out_valid SHALL rise N+1 rising edges after the accepting edge (4 for defaults). Minimum job spacing SHALL be N+3 cycles.
REQ-026 in_valid outside IDLE SHALL be ignored. Input changes after accept SHALL NOT affect the job in progress.
REQ-027 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-028 rst_n low SHALL, asynchronously and in any state, force IDLE, out_valid=0, out_pixel=0, out_sat=0, accumulator=0 and group index=0, and SHALL discard any job in progress.
REQ-029 in_ready SHALL be 0 while rst_n is low and SHALL be 1 from the first rising edge after release.

Verification (defaults: DATA_W=8, K=3, LANES=3, OUT_W=16)
REQ-030 Patch all 1, kernel all 2, bias 5, relu_en 0 -> out_pixel 23, out_sat 0; out_valid rises exactly 4 edges after accept.
REQ-031 Patch 1..9, kernel alternating +1/-1 starting +1, bias -10 -> out_pixel -5 with relu_en 0; out_pixel 0 and out_sat 0 with relu_en 1.
REQ-032 Patch all 127, kernel all 127, bias 0 -> out_pixel 32767, out_sat 1. Patch all -128, kernel all 127 -> out_pixel -32768, out_sat 1; same job with relu_en 1 -> out_pixel 0, out_sat 0.
REQ-033 Hold out_ready 0 for 10 cycles while pulsing in_valid -> out_valid, out_pixel and out_sat stable and in_ready 0 throughout; the pulses start no job; one result is delivered when out_ready rises.
REQ-034 Assert rst_n low in the second MAC cycle -> outputs 0 and in_ready 0 immediately. After release, the next job (REQ-030 stimulus) SHALL return 23.
REQ-035 Run back-to-back jobs with out_ready tied 1 and randomised signed data, K=5/LANES=5 and K=3/LANES=9 variants -> every result matches a reference model, with accepts spaced N+3 cycles.
